// File: rtl/sram_uart_dump_if.sv
// Bus bundle between the SRAM-to-UART dump engine and its surroundings:
// dump command, SRAM read port, serial line and status.
interface sram_uart_dump_if;
   logic        start;
   logic [17:0] base_address;
   logic [17:0] word_count;
   logic [17:0] sram_address;
   logic [15:0] sram_read_data;
   logic        sram_we_n;
   logic        uart_tx_o;
   logic        busy;
   logic        done;

   modport master (
      output start, base_address, word_count, sram_read_data,
      input  sram_address, sram_we_n, uart_tx_o, busy, done
   );

   modport slave (
      input  start, base_address, word_count, sram_read_data,
      output sram_address, sram_we_n, uart_tx_o, busy, done
   );
endinterface

// File: rtl/sram_uart_dump.sv
// Reads a block of 16-bit SRAM words and sends each one as two 8N1 UART frames,
// high byte first, matching the byte order of images loaded through the UART path.
module sram_uart_dump #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic              clock_50,
   input  logic              resetn,
   sram_uart_dump_if.slave   bus
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH_W1,
      S_FETCH_W2,
      S_TX_START,
      S_TX_DATA,
      S_TX_STOP
   } state_t;

   state_t            state_r;
   logic [17:0]       addr_r;
   logic [17:0]       words_left_r;
   logic [7:0]        tx_byte_r;
   logic [7:0]        lo_byte_r;
   logic              hi_byte_r;
   logic              tx_r;
   logic              busy_r;
   logic              done_r;
   logic [2:0]        bit_cnt_r;
   logic [BAUD_W-1:0] baud_cnt_r;
   logic              baud_end_s;

   assign baud_end_s        = (baud_cnt_r == BAUD_LAST);
   assign bus.sram_address  = addr_r;
   assign bus.sram_we_n     = 1'b1;
   assign bus.uart_tx_o     = tx_r;
   assign bus.busy          = busy_r;
   assign bus.done          = done_r;

   // Fetch/transmit sequencer with registered SRAM address, TX line and status.
   always_ff @(posedge clock_50) begin
      if (!resetn) begin
         state_r      <= S_IDLE;
         addr_r       <= 18'd0;
         words_left_r <= 18'd0;
         tx_byte_r    <= 8'd0;
         lo_byte_r    <= 8'd0;
         hi_byte_r    <= 1'b0;
         tx_r         <= 1'b1;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         bit_cnt_r    <= 3'd0;
         baud_cnt_r   <= '0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.word_count == 18'd0) begin
                     done_r <= 1'b1;
                  end else begin
                     words_left_r <= bus.word_count;
                     addr_r       <= bus.base_address;
                     busy_r       <= 1'b1;
                     state_r      <= S_FETCH_W1;
                  end
               end
            end
            S_FETCH_W1: begin
               state_r <= S_FETCH_W2;
            end
            // Read data for addr_r is valid here, two clocks after the address moved.
            S_FETCH_W2: begin
               tx_byte_r  <= bus.sram_read_data[15:8];
               lo_byte_r  <= bus.sram_read_data[7:0];
               hi_byte_r  <= 1'b1;
               tx_r       <= 1'b0;
               baud_cnt_r <= '0;
               state_r    <= S_TX_START;
            end
            S_TX_START: begin
               if (baud_end_s) begin
                  baud_cnt_r <= '0;
                  tx_r       <= tx_byte_r[0];
                  tx_byte_r  <= {1'b0, tx_byte_r[7:1]};
                  bit_cnt_r  <= 3'd0;
                  state_r    <= S_TX_DATA;
               end else begin
                  baud_cnt_r <= baud_cnt_r + 1'b1;
               end
            end
            S_TX_DATA: begin
               if (baud_end_s) begin
                  baud_cnt_r <= '0;
                  if (bit_cnt_r == 3'd7) begin
                     tx_r    <= 1'b1;
                     state_r <= S_TX_STOP;
                  end else begin
                     tx_r      <= tx_byte_r[0];
                     tx_byte_r <= {1'b0, tx_byte_r[7:1]};
                     bit_cnt_r <= bit_cnt_r + 3'd1;
                  end
               end else begin
                  baud_cnt_r <= baud_cnt_r + 1'b1;
               end
            end
            // Low byte follows the high byte with no idle gap; words are separated by the fetch.
            S_TX_STOP: begin
               if (baud_end_s) begin
                  baud_cnt_r <= '0;
                  if (hi_byte_r) begin
                     hi_byte_r <= 1'b0;
                     tx_byte_r <= lo_byte_r;
                     tx_r      <= 1'b0;
                     state_r   <= S_TX_START;
                  end else if (words_left_r > 18'd1) begin
                     words_left_r <= words_left_r - 18'd1;
                     addr_r       <= addr_r + 18'd1;
                     state_r      <= S_FETCH_W1;
                  end else begin
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     state_r <= S_IDLE;
                  end
               end else begin
                  baud_cnt_r <= baud_cnt_r + 1'b1;
               end
            end
            default: begin
               tx_r    <= 1'b1;
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_uart_dump.sv
// Scoreboard bench for sram_uart_dump: expected bytes are queued from an SRAM
// model when a dump is launched and popped as the UART monitor decodes frames.
module tb_sram_uart_dump;

   localparam int CPB = 4;

   logic clock_50 = 1'b0;
   logic resetn   = 1'b0;

   sram_uart_dump_if bus ();

   sram_uart_dump #(.CLKS_PER_BIT(CPB)) dut (
      .clock_50 (clock_50),
      .resetn   (resetn),
      .bus      (bus)
   );

   always #10 clock_50 = ~clock_50;

   int         checks   = 0;
   int         errors   = 0;
   int         bytes_rx = 0;
   int         we_bad   = 0;
   logic [7:0]  exp_q[$];
   logic [17:0] addr_q[$];
   int          gaps_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] sram_val(input logic [17:0] a);
      if (a == 18'h00100) return 16'hA53C;
      return {a[7:0] ^ 8'h5A, a[15:8] ^ {6'd0, a[17:16]} ^ 8'h96};
   endfunction

   // SRAM model: data for an address is sampled by the DUT two edges after the address changes
   always @(posedge clock_50) bus.sram_read_data <= sram_val(bus.sram_address);

   always @(negedge clock_50) if (bus.sram_we_n !== 1'b1) we_bad++;

   // UART monitor: decodes 8N1 frames, records idle gaps, scores bytes
   initial begin : uart_monitor
      logic [7:0] b;
      logic       stop_bit;
      bit         ab;
      bit         gap_valid;
      int         gap_cnt;
      gap_valid = 1'b0;
      gap_cnt   = 0;
      b         = 8'd0;
      stop_bit  = 1'b0;
      forever begin
         @(negedge clock_50);
         if (!resetn) begin
            gap_valid = 1'b0;
         end else if (bus.uart_tx_o === 1'b0) begin
            if (gap_valid) gaps_q.push_back(gap_cnt);
            gap_valid = 1'b0;
            ab = 1'b0;
            for (int k = 0; k < 9; k++) begin
               repeat (CPB) begin
                  @(negedge clock_50);
                  if (!resetn) ab = 1'b1;
               end
               if (k < 8) b[k] = bus.uart_tx_o;
               else       stop_bit = bus.uart_tx_o;
            end
            if (!ab) begin
               check("stop_bit", {31'd0, stop_bit}, 32'd1);
               if (exp_q.size() == 0) check("byte_extra", exp_q.size(), 32'd1);
               else                   check("byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
               bytes_rx++;
               gap_cnt   = 0;
               gap_valid = 1'b1;
            end
         end else begin
            gap_cnt++;
         end
      end
   end

   task automatic push_dump(input logic [17:0] base, input int count);
      logic [15:0] w;
      for (int i = 0; i < count; i++) begin
         w = sram_val(base + 18'(i));
         exp_q.push_back(w[15:8]);
         exp_q.push_back(w[7:0]);
      end
   endtask

   task automatic start_dump(input logic [17:0] base, input int count, input bit hold);
      @(negedge clock_50);
      bus.base_address = base;
      bus.word_count   = 18'(count);
      bus.start        = 1'b1;
      push_dump(base, count);
      addr_q.delete();
      @(negedge clock_50);
      if (!hold) bus.start = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int n);
      n = 0;
      do begin
         @(negedge clock_50);
         n++;
         if (bus.busy && (addr_q.size() == 0 || addr_q[$] != bus.sram_address))
            addr_q.push_back(bus.sram_address);
      end while (!bus.done && n < bound);
      if (!bus.done) check("done_timeout", {31'd0, bus.done}, 32'd1);
   endtask

   initial begin : main
      int n;
      int b0;
      int g;
      int hits;
      logic [17:0] exp_addr [3];
      exp_addr[0] = 18'h3FFFE;
      exp_addr[1] = 18'h3FFFF;
      exp_addr[2] = 18'h00000;
      bus.start        = 1'b0;
      bus.base_address = 18'd0;
      bus.word_count   = 18'd0;

      repeat (3) @(negedge clock_50);
      check("rst_tx",   {31'd0, bus.uart_tx_o}, 32'd1);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_addr", {14'd0, bus.sram_address}, 32'd0);
      resetn = 1'b1;
      repeat (2) @(negedge clock_50);

      // 1) single word, latency and frame length
      b0 = bytes_rx;
      bus.base_address = 18'h00100;
      bus.word_count   = 18'd1;
      bus.start        = 1'b1;
      push_dump(18'h00100, 1);
      n = 0;
      do begin
         @(negedge clock_50);
         bus.start = 1'b0;
         n++;
      end while (bus.uart_tx_o !== 1'b0 && n < 20);
      check("t1_start_latency", n, 32'd3);
      wait_done(300, n);
      check("t1_done_latency", n, 32'd80);
      check("t1_busy_at_done", {31'd0, bus.busy}, 32'd0);
      check("t1_bytes", bytes_rx - b0, 32'd2);
      check("t1_queue_empty", exp_q.size(), 32'd0);

      // 2) address wrap
      b0 = bytes_rx;
      start_dump(18'h3FFFE, 3, 1'b0);
      wait_done(400, n);
      check("t2_addr_count", addr_q.size(), 32'd3);
      if (addr_q.size() == 3)
         for (int i = 0; i < 3; i++) check("t2_addr_seq", {14'd0, addr_q[i]}, {14'd0, exp_addr[i]});
      check("t2_bytes", bytes_rx - b0, 32'd6);
      check("t2_queue_empty", exp_q.size(), 32'd0);

      // 3) zero count
      @(negedge clock_50);
      bus.word_count = 18'd0;
      bus.start      = 1'b1;
      @(negedge clock_50);
      check("t3_done_pulse", {31'd0, bus.done}, 32'd1);
      check("t3_busy",       {31'd0, bus.busy}, 32'd0);
      check("t3_tx",         {31'd0, bus.uart_tx_o}, 32'd1);
      bus.start = 1'b0;
      @(negedge clock_50);
      check("t3_done_fall",  {31'd0, bus.done}, 32'd0);
      hits = 0;
      repeat (5) begin
         @(negedge clock_50);
         if (bus.busy !== 1'b0 || bus.uart_tx_o !== 1'b1) hits++;
      end
      check("t3_quiet", hits, 32'd0);

      // 4) start held high retriggers
      b0 = bytes_rx;
      start_dump(18'h00040, 2, 1'b1);
      wait_done(400, n);
      check("t4_bytes_first", bytes_rx - b0, 32'd4);
      push_dump(18'h00040, 2);
      @(negedge clock_50);
      check("t4_retrigger_busy", {31'd0, bus.busy}, 32'd1);
      check("t4_retrigger_done", {31'd0, bus.done}, 32'd0);
      bus.start = 1'b0;
      wait_done(400, n);
      check("t4_bytes_total", bytes_rx - b0, 32'd8);
      check("t4_queue_empty", exp_q.size(), 32'd0);

      // 6) inter-word idle gap
      start_dump(18'h00080, 2, 1'b0);
      wait_done(400, n);
      g = gaps_q.size();
      check("t6_gap_count", (g >= 3) ? 32'd1 : 32'd0, 32'd1);
      if (g >= 3) begin
         check("t6_idle_hi_lo_w1", gaps_q[g-3] - 3, 32'd0);
         check("t6_idle_w1_w2",    gaps_q[g-2] - 3, 32'd2);
         check("t6_idle_hi_lo_w2", gaps_q[g-1] - 3, 32'd0);
      end
      check("t6_we_n", we_bad, 32'd0);

      // 5) reset mid data bit of word 2
      b0 = bytes_rx;
      start_dump(18'h00200, 3, 1'b0);
      n = 0;
      while (bytes_rx - b0 < 2 && n < 300) begin
         @(negedge clock_50);
         n++;
      end
      check("t5_word1_bytes", bytes_rx - b0, 32'd2);
      n = 0;
      while (bus.uart_tx_o !== 1'b0 && n < 20) begin
         @(negedge clock_50);
         n++;
      end
      repeat (CPB + 2) @(negedge clock_50);
      exp_q.delete();
      resetn = 1'b0;
      @(negedge clock_50);
      check("t5_tx",   {31'd0, bus.uart_tx_o}, 32'd1);
      check("t5_busy", {31'd0, bus.busy}, 32'd0);
      check("t5_addr", {14'd0, bus.sram_address}, 32'd0);
      check("t5_done", {31'd0, bus.done}, 32'd0);
      @(negedge clock_50);
      resetn = 1'b1;
      hits = 0;
      repeat (60) begin
         @(negedge clock_50);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) hits++;
      end
      check("t5_no_done", hits, 32'd0);
      check("t5_no_more_bytes", bytes_rx - b0, 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
